// File: rtl/softmax_pkg.sv
// Shared softmax definitions: pass FSM states, exp range constant and the exp LUT formula.
// Used by the score exp stage and by the downstream row normaliser.
package softmax_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        MAX    = 3'd2,
        EXP    = 3'd3,
        OUTPUT = 3'd4,
        DONE   = 3'd5
    } state_t;

    // The LUT spans exponents 0 .. -8.0; anything further below underflows to zero.
    localparam int EXP_RANGE_LOG2 = 3;

    function automatic int expLutEntry(input int idx, input int fracBits, input int lutBits);
        real x;
        x = $exp(-(real'(idx) * real'(1 << EXP_RANGE_LOG2)) / real'(1 << lutBits));
        return $rtoi(x * real'(1 << fracBits) + 0.5);
    endfunction

endpackage

// File: rtl/exp_lut.sv
// Registered ROM of round(exp(-i*8/2^EXP_LUT_BITS) * 2^FRAC_BITS), one-cycle read latency.
module exp_lut
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 8,
    parameter int EXP_LUT_BITS = 8
) (
    input  logic                    clk,
    input  logic [EXP_LUT_BITS-1:0] addr,
    output logic [DATA_WIDTH-1:0]   data
);

    localparam int DEPTH = 1 << EXP_LUT_BITS;

    logic [DATA_WIDTH-1:0] w_rom [DEPTH];

    // Table contents are elaboration-time constants.
    for (genvar g = 0; g < DEPTH; g++) begin : gRom
        assign w_rom[g] = DATA_WIDTH'(expLutEntry(g, FRAC_BITS, EXP_LUT_BITS));
    end

    always_ff @(posedge clk) begin
        data <= w_rom[addr];
    end

endmodule

// File: rtl/score_exp_stage.sv
// Softmax numerator stage: per (l,n) row computes exp(S - rowmax) in fixed point.
// One pass = LOAD, a serial max scan, a serial LUT exp with one flush cycle, then a packed output.
module score_exp_stage
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int L            = 8,
    parameter int N            = 1,
    parameter int FRAC_BITS    = 8,
    parameter int EXP_LUT_BITS = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [DATA_WIDTH*L*N*L-1:0]      S_in,
    output logic [DATA_WIDTH*L*N*L-1:0]      E_out,
    output logic                             busy,
    output logic                             done,
    output logic                             out_valid
);

    localparam int NE        = L * N * L;
    localparam int ROWS      = L * N;
    localparam int CW        = $clog2(NE + 1);
    localparam int EW        = (NE > 1) ? $clog2(NE) : 1;
    localparam int ROWW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COLW      = (L > 1) ? $clog2(L) : 1;
    localparam int EXP_LIMIT = 1 << (FRAC_BITS + EXP_RANGE_LOG2);
    localparam int LUT_SHIFT = FRAC_BITS + EXP_RANGE_LOG2 - EXP_LUT_BITS;

    state_t                       r_state;
    logic [CW-1:0]                r_cnt;
    logic [ROWW-1:0]              r_row;
    logic [COLW-1:0]              r_col;
    logic                         r_pendValid;
    logic [EW-1:0]                r_pendIdx;
    logic                         r_pendZero;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_outValid;
    logic [DATA_WIDTH*NE-1:0]     r_eOut;

    logic signed [DATA_WIDTH-1:0] r_scores [NE];
    logic signed [DATA_WIDTH-1:0] r_max    [ROWS];
    logic [DATA_WIDTH-1:0]        r_exp    [NE];

    logic [EW-1:0]                w_elem;
    logic signed [DATA_WIDTH-1:0] w_sel;
    logic signed [DATA_WIDTH-1:0] w_rowMax;
    logic signed [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH:0]          w_mag;
    logic                         w_zero;
    logic [EXP_LUT_BITS-1:0]      w_lutAddr;
    logic [DATA_WIDTH-1:0]        w_lutData;
    logic                         w_issue;
    logic                         w_colLast;
    logic [DATA_WIDTH*NE-1:0]     w_packed;

    // d = S - max at one extra bit cannot overflow and is never positive, so m = -d is exact.
    always_comb begin
        w_elem    = EW'(r_cnt);
        w_sel     = r_scores[w_elem];
        w_rowMax  = r_max[r_row];
        w_diff    = {w_sel[DATA_WIDTH-1], w_sel} - {w_rowMax[DATA_WIDTH-1], w_rowMax};
        w_mag     = -w_diff;
        w_zero    = (w_mag >= (DATA_WIDTH+1)'(EXP_LIMIT));
        w_lutAddr = EXP_LUT_BITS'(w_mag >> LUT_SHIFT);
        w_issue   = (r_cnt < CW'(NE));
        w_colLast = (r_col == COLW'(L - 1));
    end

    always_comb begin
        w_packed = '0;
        for (int e = 0; e < NE; e++) begin
            w_packed[e*DATA_WIDTH +: DATA_WIDTH] = r_exp[e];
        end
    end

    exp_lut #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRAC_BITS   (FRAC_BITS),
        .EXP_LUT_BITS(EXP_LUT_BITS)
    ) u_expLut (
        .clk (clk),
        .addr(w_lutAddr),
        .data(w_lutData)
    );

    // Pass sequencing; start is only looked at in IDLE, so it is ignored for the whole pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_pendValid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_outValid  <= 1'b0;
            r_eOut      <= '0;
        end else begin
            r_done     <= 1'b0;
            r_outValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state     <= MAX;
                    r_cnt       <= '0;
                    r_row       <= '0;
                    r_col       <= '0;
                    r_pendValid <= 1'b0;
                end
                MAX: begin
                    if (w_colLast) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(NE - 1)) begin
                        r_state <= EXP;
                        r_cnt   <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                EXP: begin
                    r_pendValid <= w_issue;
                    if (w_issue) begin
                        if (w_colLast) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                    r_cnt <= r_cnt + 1'b1;
                    // The extra cycle at r_cnt == NE drains the registered LUT read.
                    if (r_cnt == CW'(NE)) begin
                        r_state <= OUTPUT;
                        r_cnt   <= '0;
                    end
                end
                OUTPUT: begin
                    r_eOut  <= w_packed;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_outValid <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Working arrays are fully rewritten each pass before use, so they carry no reset.
    always_ff @(posedge clk) begin
        case (r_state)
            LOAD: begin
                for (int e = 0; e < NE; e++) begin
                    r_scores[e] <= S_in[e*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            MAX: begin
                if (r_col == '0 || w_sel > w_rowMax) begin
                    r_max[r_row] <= w_sel;
                end
            end
            EXP: begin
                if (r_pendValid) begin
                    r_exp[r_pendIdx] <= r_pendZero ? '0 : w_lutData;
                end
                r_pendIdx  <= w_elem;
                r_pendZero <= w_zero;
            end
            default: ;
        endcase
    end

    assign E_out     = r_eOut;
    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_outValid;

endmodule

// File: doc/score_exp_stage.md
SCORE_EXP_STAGE -- requirements
Module: score_exp_stage

Interface
REQ-001 SHALL expose parameters, one per line:
- DATA_WIDTH, 16, score/output element width
- L, 8, sequence length
- N, 1, attention head count
- FRAC_BITS, 8, fractional bits of input and output fixed point
- EXP_LUT_BITS, 8, exp LUT address width
REQ-002 SHALL expose ports, one per line:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a pass
- S_in  in  DATA_WIDTH*L*N*L  raw signed scores, shape (L,N,L), element (l,n,l2) at bit offset ((l*N*L)+(n*L)+l2)*DATA_WIDTH
- E_out  out  DATA_WIDTH*L*N*L  unsigned exp values, same packing
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle completion pulse
- out_valid  out  1  one-cycle pulse coincident with done
REQ-003 Reset rst_n SHALL be asynchronous, active-low; clock SHALL be clk.

Function
REQ-004 The block SHALL compute E[l][n][c] = exp(S[l][n][c] - max_c S[l][n][c]) per row (l,n), feeding the downstream row normaliser.
REQ-005 The FSM SHALL have states IDLE, LOAD, MAX, EXP, OUTPUT, DONE; transitions SHALL be IDLE->LOAD on start, LOAD->MAX after 1 cycle, MAX->EXP after L*N*L cycles, EXP->OUTPUT after L*N*L+1 cycles, OUTPUT->DONE after 1 cycle, DONE->IDLE after 1 cycle.
REQ-006 LOAD SHALL capture all of S_in into an internal array; S_in SHALL be don't-care in all other states.
REQ-007 MAX SHALL scan one element per cycle in row-major (row, head, col) order; each row's running max SHALL be initialised from column 0 using signed comparison.
REQ-008 EXP SHALL issue one element per cycle; the LUT read SHALL be registered, giving one flush cycle.
REQ-009 d = S - max SHALL be computed at DATA_WIDTH+1 bits signed (d <= 0) and SHALL never overflow.
REQ-010 With m = -d, the exp result SHALL be 0 when m >= 8.0, i.e. m >= 2^(FRAC_BITS+3).
REQ-011 Otherwise the result SHALL be LUT[m >> (FRAC_BITS+3-EXP_LUT_BITS)].
REQ-012 LUT[i] SHALL equal round(exp(-i*8/2^EXP_LUT_BITS) * 2^FRAC_BITS); LUT[0] SHALL be 2^FRAC_BITS, i.e. 1.0.
REQ-013 OUTPUT SHALL pack all results into E_out in one cycle; E_out SHALL hold until the next OUTPUT.
REQ-014 done and out_valid SHALL be registered and high for exactly one cycle, 2*L*N*L+4 clocks after the edge that samples start in IDLE.
REQ-015 start SHALL be ignored while busy, including start held high through DONE. A start high in the IDLE cycle after DONE SHALL begin a new pass.
REQ-016 Reset asserted in any state SHALL abort the pass immediately; no partial E_out update SHALL survive.

Reset
REQ-017 On reset: state=IDLE; E_out=0; done=0; out_valid=0; busy=0; all counters=0. The internal score and max arrays need no reset.

Structure
REQ-018 The state typedef, the EXP_RANGE_LOG2=3 constant and the LUT formula SHALL live in shared package softmax_pkg, which is also used by the downstream normaliser.
REQ-019 The exp LUT SHALL be sub-module exp_lut: registered ROM, parameters DATA_WIDTH, FRAC_BITS, EXP_LUT_BITS; ports clk, addr, data.

Verification (L=8, N=1, FRAC_BITS=8)
REQ-020 All scores 0 -> every E_out element 256; done pulses exactly 132 cycles after start.
REQ-021 Row 0 = {256, 0, 0, 0, 0, 0, 0, 0} -> E = {256, 94, 94, 94, 94, 94, 94, 94}; other rows all 256.
REQ-022 Row = {-128 x 7, 0x8000} -> -128 elements give 256; 0x8000 (d = -127.5) gives 0. Row = {0x7FFF, 0x8000, ...} -> no overflow; non-max elements give 0.
REQ-023 Row = {0, -2048, -2047, ...} -> d = -8.0 gives 0; d = -7.996 gives LUT[255] = 0.
REQ-024 start pulsed during MAX and EXP -> ignored; exactly one done pulse; E_out matches single-pass expectation.
REQ-025 rst_n low mid-EXP -> busy=0 and E_out=0 immediately. A fresh start after release -> correct results in 132 cycles.
